// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one sequential multiplier core
// Grants one requester at a time, runs the core (or bypasses it on a zero operand) and returns the product.
module mult_arbiter #(
  parameter int N           = 4,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT     = 32,
  parameter int BYPASS_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   op_b,
  input  logic [N*WIDTH-1:0]   op_q,
  output logic [N-1:0]         req_ack,
  output logic [N-1:0]         rsp_valid,
  input  logic [N-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_err,
  output logic                 mul_rst,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_q,
  input  logic [2*WIDTH-1:0]   mul_result,
  input  logic                 mul_done,
  output logic                 busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic                 mul_rst_q, mul_rst_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [WIDTH-1:0]     mul_q_q, mul_q_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic [IW-1:0]        pick;
  logic [WIDTH-1:0]     pick_b;
  logic [WIDTH-1:0]     pick_q;
  logic                 req_any;

  // First requesting index at or after ptr, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] g;
    logic          f;
    int            idx;
    g = '0;
    f = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(p) + k) % N;
      if (!f && r[idx]) begin
        f = 1'b1;
        g = IW'(idx);
      end
    end
    return g;
  endfunction

  assign req_any = |req;
  assign pick    = rr_pick(req, ptr_q);
  assign pick_b  = op_b[pick*WIDTH +: WIDTH];
  assign pick_q  = op_q[pick*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    mul_rst_d = mul_rst_q;
    mul_b_d   = mul_b_q;
    mul_q_d   = mul_q_q;
    result_d  = result_q;
    err_d     = err_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE: begin
        mul_rst_d = 1'b1;
        if (req_any) begin
          gnt_d   = pick;
          mul_b_d = pick_b;
          mul_q_d = pick_q;
          err_d   = 1'b0;
          if ((BYPASS_ZERO != 0) && ((pick_b == '0) || (pick_q == '0))) begin
            result_d = '0;
            state_d  = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        mul_rst_d = 1'b0;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A done arriving on the last allowed cycle still wins over the abort.
        if (mul_done) begin
          result_d  = mul_result;
          mul_rst_d = 1'b1;
          state_d   = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_d  = '0;
          err_d     = 1'b1;
          mul_rst_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          ptr_d   = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      mul_rst_q <= 1'b1;
      mul_b_q   <= '0;
      mul_q_q   <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      mul_rst_q <= mul_rst_d;
      mul_b_q   <= mul_b_d;
      mul_q_q   <= mul_q_d;
      result_q  <= result_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  assign req_ack    = (state_q == S_IDLE && req_any && !rst) ? (ONE_N << pick) : '0;
  assign rsp_valid  = (state_q == S_RESP && !rst) ? (ONE_N << gnt_q) : '0;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign mul_rst    = mul_rst_q;
  assign mul_b      = mul_b_q;
  assign mul_q      = mul_q_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized bench for mult_arbiter against a transaction-level model
// Includes a second instance with the zero bypass disabled.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, req_ack, rsp_valid, rsp_ready;
  logic [N*W-1:0]   op_b, op_q;
  logic [2*W-1:0]   rsp_result, mul_result;
  logic             rsp_err, mul_rst, mul_done, busy;
  logic [W-1:0]     mul_b, mul_q;

  logic [N-1:0]     nb_req, nb_ack, nb_valid, nb_ready;
  logic [N*W-1:0]   nb_opb, nb_opq;
  logic [2*W-1:0]   nb_res, nb_mres;
  logic             nb_err, nb_mrst, nb_done, nb_busy;
  logic [W-1:0]     nb_mb, nb_mq;

  mult_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO), .BYPASS_ZERO(1)) dut (
    .clk(clk), .rst(rst), .req(req), .op_b(op_b), .op_q(op_q),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .mul_rst(mul_rst),
    .mul_b(mul_b), .mul_q(mul_q), .mul_result(mul_result),
    .mul_done(mul_done), .busy(busy)
  );

  mult_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO), .BYPASS_ZERO(0)) dut_nb (
    .clk(clk), .rst(rst), .req(nb_req), .op_b(nb_opb), .op_q(nb_opq),
    .req_ack(nb_ack), .rsp_valid(nb_valid), .rsp_ready(nb_ready),
    .rsp_result(nb_res), .rsp_err(nb_err), .mul_rst(nb_mrst),
    .mul_b(nb_mb), .mul_q(nb_mq), .mul_result(nb_mres),
    .mul_done(nb_done), .busy(nb_busy)
  );

  // Core models: count cycles out of reset, pulse done after core_lat cycles (0 = never).
  int   core_lat = 0;
  int   core_cnt = 0;
  int   nb_cnt   = 0;
  logic spur_done = 1'b0;
  always @(posedge clk) core_cnt <= mul_rst ? 0 : core_cnt + 1;
  always @(posedge clk) nb_cnt   <= nb_mrst ? 0 : nb_cnt + 1;
  assign mul_done   = spur_done || (!mul_rst && core_lat != 0 && core_cnt == core_lat - 1);
  assign mul_result = {8'b0, mul_b} * {8'b0, mul_q};
  assign nb_done    = !nb_mrst && nb_cnt == 2;
  assign nb_mres    = {8'b0, nb_mb} * {8'b0, nb_mq};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0]   b_arr [N];
  logic [W-1:0]   q_arr [N];
  int             ptr_m = 0;
  logic [2*W-1:0] last_res;
  logic           last_err;

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the response is accepted.
  task automatic txn(input logic [N-1:0] rq, input int lat, input int stall, output int g);
    int             e, cyc, low, exp_low;
    logic [2*W-1:0] exp_res;
    logic           exp_err;
    logic [N-1:0]   oth;
    req = rq;
    core_lat = lat;
    for (int i = 0; i < N; i++) begin
      op_b[i*W +: W] = b_arr[i];
      op_q[i*W +: W] = q_arr[i];
    end
    e = model_pick(rq, ptr_m);
    #1;
    cyc = 0;
    while (req_ack == '0 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("ack", 32'(req_ack), 32'(1) << e);
    g = oh_idx(req_ack);
    if (b_arr[e] == 0 || q_arr[e] == 0) begin
      exp_res = '0; exp_err = 1'b0; exp_low = 0;
    end else if (lat != 0 && lat <= TO) begin
      exp_res = 16'(int'(b_arr[e]) * int'(q_arr[e])); exp_err = 1'b0; exp_low = lat;
    end else begin
      exp_res = '0; exp_err = 1'b1; exp_low = TO;
    end
    @(negedge clk);
    req[e] = 1'b0;
    chk("busy", 32'(busy), 1);
    cyc = 1; low = 0;
    while (rsp_valid == '0 && cyc < 100) begin
      if (!mul_rst) low++;
      @(negedge clk); cyc++;
    end
    chk("rsp_latency", cyc, (exp_low == 0 && !exp_err) ? ((lat == 0 && exp_res == 0 && (b_arr[e] == 0 || q_arr[e] == 0)) ? 1 : (b_arr[e] == 0 || q_arr[e] == 0) ? 1 : 2 + exp_low) : 2 + exp_low);
    chk("wait_cycles", low, exp_low);
    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e);
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("mul_rst_resp", 32'(mul_rst), 1);
    last_res = rsp_result;
    last_err = rsp_err;
    for (int s = 0; s < stall; s++) begin
      oth = N'($urandom) & ~(N'(1) << e);
      rsp_ready = oth;
      spur_done = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'(1) << e);
      chk("stall_result", 32'(rsp_result), 32'(exp_res));
      chk("stall_noack", 32'(req_ack), 0);
    end
    spur_done = 1'b0;
    rsp_ready = N'(1) << e;
    @(negedge clk);
    rsp_ready = '0;
    chk("released", 32'(rsp_valid), 0);
    ptr_m = (e + 1) % N;
  endtask

  int g;
  int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
  logic [N-1:0] rq_hold;
  int cyc, low, e;

  initial begin
    rst = 1'b1;
    req = '0; rsp_ready = '0; op_b = '0; op_q = '0;
    nb_req = '0; nb_ready = '0; nb_opb = '0; nb_opq = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_rst", 32'(mul_rst), 1);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_mul_q", 32'(mul_q), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_err", 32'(rsp_err), 0);
    @(negedge clk);

    // Bypass disabled: zero operand still runs the core.
    nb_opb[2*W +: W] = 8'd0;
    nb_opq[2*W +: W] = 8'd200;
    nb_req = 4'b0100;
    #1;
    cyc = 0;
    while (nb_ack == '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("nb_ack", 32'(nb_ack), 32'h4);
    @(negedge clk);
    nb_req = '0;
    cyc = 0; low = 0;
    while (nb_valid == '0 && cyc < 100) begin
      if (!nb_mrst) low++;
      @(negedge clk); cyc++;
    end
    chk("nb_launched", low, 3);
    chk("nb_valid", 32'(nb_valid), 32'h4);
    chk("nb_result", 32'(nb_res), 0);
    chk("nb_err", 32'(nb_err), 0);
    nb_ready = 4'b0100;
    @(negedge clk);
    nb_ready = '0;
    chk("nb_idle", 32'(nb_busy), 0);

    // Round robin with every requester held, then a sparse pattern.
    for (int i = 0; i < N; i++) begin b_arr[i] = 8'(i + 2); q_arr[i] = 8'(i + 7); end
    for (int k = 0; k < 6; k++) begin
      txn(4'b1111, 3, 0, g);
      chk("rr_order", g, exp_rr[k]);
    end
    txn(4'b1010, 4, 0, g);
    chk("rr_order", g, exp_rr[6]);
    txn(4'b0010, 4, 0, g);
    chk("rr_order", g, exp_rr[7]);

    b_arr[0] = 8'd13; q_arr[0] = 8'd11;
    txn(4'b0001, 19, 0, g);
    chk("single_const", 32'(last_res), 32'h008F);

    b_arr[2] = 8'd0; q_arr[2] = 8'd200;
    txn(4'b0100, 19, 2, g);
    b_arr[3] = 8'd77; q_arr[3] = 8'd0;
    txn(4'b1000, 19, 0, g);

    b_arr[1] = 8'd255; q_arr[1] = 8'd255;
    txn(4'b0010, 10, 5, g);
    chk("bp_const", 32'(last_res), 32'hFE01);

    b_arr[0] = 8'd9; q_arr[0] = 8'd9;
    txn(4'b0001, 0, 1, g);
    chk("timeout_err", 32'(last_err), 1);
    txn(4'b0001, 6, 0, g);
    txn(4'b0100, 32, 0, g);
    txn(4'b0100, 33, 0, g);

    // Reset while the core is running.
    for (int i = 0; i < N; i++) begin
      b_arr[i] = 8'(i + 3); q_arr[i] = 8'(i + 5);
      op_b[i*W +: W] = b_arr[i]; op_q[i*W +: W] = q_arr[i];
    end
    core_lat = 0;
    req = 4'b1111;
    #1;
    e = model_pick(req, ptr_m);
    chk("mid_ack", 32'(req_ack), 32'(1) << e);
    @(negedge clk);
    req[e] = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_inwait", 32'(mul_rst), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_mul_rst", 32'(mul_rst), 1);
    chk("mid_valid", 32'(rsp_valid), 0);
    ptr_m = 0;
    rq_hold = req;
    txn(rq_hold, 5, 0, g);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) begin
        b_arr[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        q_arr[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 40), $urandom_range(0, 3), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
